// File: rtl/time_setter.sv
// Edit/step unit for the clock's time and alarm values: captures the running
// time on edit entry, steps the selected field with auto-repeat, and pulses commit on exit.
module time_setter #(
   parameter int H_MAX         = 23,
   parameter int M_MAX         = 59,
   parameter int S_MAX         = 59,
   parameter int HOLD_CYCLES   = 50_000_000,
   parameter int REPEAT_CYCLES = 10_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       edit_en,
   input  logic       btn_next,
   input  logic       btn_inc,
   input  logic       btn_dec,
   input  logic [4:0] cur_h,
   input  logic [5:0] cur_m,
   input  logic [5:0] cur_s,
   output logic [4:0] hour,
   output logic [5:0] minute,
   output logic [5:0] second,
   output logic [1:0] field,
   output logic       editing,
   output logic       commit
);

   typedef enum logic {IDLE, EDIT} state_e;

   localparam int CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] HOLD_C  = CW'(HOLD_CYCLES);
   localparam logic [CW-1:0] REP_C   = CW'(REPEAT_CYCLES);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [5:0] H_MAX_C = 6'(H_MAX);
   localparam logic [5:0] M_MAX_C = 6'(M_MAX);
   localparam logic [5:0] S_MAX_C = 6'(S_MAX);

   state_e          state_q, state_d;
   logic [4:0]      hour_q, hour_d;
   logic [5:0]      minute_q, minute_d;
   logic [5:0]      second_q, second_d;
   logic [1:0]      field_q, field_d;
   logic            commit_q, commit_d;
   logic            nextPrev_q, incPrev_q, decPrev_q;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            repeat_q, repeat_d;
   logic            stepEn;

   // Values loaded above their limit wrap to zero on the next increment.
   function automatic logic [5:0] stepValue(input logic [5:0] value, input logic [5:0] maxValue,
                                            input logic up);
      if (up)
         return (value >= maxValue) ? 6'd0 : value + 6'd1;
      else
         return (value == 6'd0) ? maxValue : value - 6'd1;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         hour_q     <= '0;
         minute_q   <= '0;
         second_q   <= '0;
         field_q    <= '0;
         commit_q   <= 1'b0;
         nextPrev_q <= 1'b0;
         incPrev_q  <= 1'b0;
         decPrev_q  <= 1'b0;
         cnt_q      <= '0;
         repeat_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         hour_q     <= hour_d;
         minute_q   <= minute_d;
         second_q   <= second_d;
         field_q    <= field_d;
         commit_q   <= commit_d;
         nextPrev_q <= btn_next;
         incPrev_q  <= btn_inc;
         decPrev_q  <= btn_dec;
         cnt_q      <= cnt_d;
         repeat_q   <= repeat_d;
      end
   end

   // cnt_q counts edges since the last step; zero means no press is being tracked.
   always_comb begin
      state_d  = state_q;
      hour_d   = hour_q;
      minute_d = minute_q;
      second_d = second_q;
      field_d  = field_q;
      commit_d = 1'b0;
      cnt_d    = '0;
      repeat_d = 1'b0;
      stepEn   = 1'b0;
      case (state_q)
         IDLE: begin
            if (edit_en) begin
               state_d  = EDIT;
               hour_d   = cur_h;
               minute_d = cur_m;
               second_d = cur_s;
               field_d  = 2'd0;
            end
         end
         EDIT: begin
            if (!edit_en) begin
               state_d  = IDLE;
               commit_d = 1'b1;
            end else begin
               if (btn_next && !nextPrev_q)
                  field_d = (field_q == 2'd2) ? 2'd0 : field_q + 2'd1;
               if (btn_inc ^ btn_dec) begin
                  if ((btn_inc && !incPrev_q) || (btn_dec && !decPrev_q)) begin
                     stepEn = 1'b1;
                     cnt_d  = CNT_ONE;
                  end else if (cnt_q != '0) begin
                     if (cnt_q == (repeat_q ? REP_C : HOLD_C)) begin
                        stepEn   = 1'b1;
                        cnt_d    = CNT_ONE;
                        repeat_d = 1'b1;
                     end else begin
                        cnt_d    = cnt_q + CNT_ONE;
                        repeat_d = repeat_q;
                     end
                  end
               end
               if (stepEn) begin
                  case (field_q)
                     2'd0:    hour_d   = 5'(stepValue({1'b0, hour_q}, H_MAX_C, btn_inc));
                     2'd1:    minute_d = stepValue(minute_q, M_MAX_C, btn_inc);
                     default: second_d = stepValue(second_q, S_MAX_C, btn_inc);
                  endcase
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      hour    = hour_q;
      minute  = minute_q;
      second  = second_q;
      field   = field_q;
      editing = (state_q == EDIT);
      commit  = commit_q;
   end

endmodule

// File: doc/time_setter.md
# time_setter

Parametrised time/alarm setting unit for the electronic-clock design. While editing is enabled it captures the running time, lets the user select a field (hour/minute/second), and steps it up or down. Steps happen once per press, with auto-repeat while a button is held. On leaving edit mode it issues a one-cycle commit pulse so the timekeeper or alarm register can load the edited value. It sits between the debounced key block and the clock counter / alarm compare logic.

## Interface
- H_MAX, default 23: hour wrap limit (23 for 24 h; any value 1..31).
- M_MAX, default 59: minute wrap limit (1..63).
- S_MAX, default 59: second wrap limit (1..63).
- HOLD_CYCLES, default 50_000_000: cycles a key must be held before auto-repeat starts (≥2).
- REPEAT_CYCLES, default 10_000_000: cycles between auto-repeat steps (≥1).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- edit_en  in  1  level; 1 = edit mode requested.
- btn_next  in  1  debounced level; rising edge selects next field.
- btn_inc  in  1  debounced level; increment selected field.
- btn_dec  in  1  debounced level; decrement selected field.
- cur_h  in  5  running hour, loaded on edit entry.
- cur_m  in  6  running minute, loaded on edit entry.
- cur_s  in  6  running second, loaded on edit entry.
- hour  out  5  working hour value.
- minute  out  6  working minute value.
- second  out  6  working second value.
- field  out  2  selected field: 0 = hour, 1 = minute, 2 = second; never 3.
- editing  out  1  1 while in EDIT state.
- commit  out  1  one-cycle pulse on exit from EDIT; hour/minute/second are valid in the same cycle.

## Operation
- Reset (rst_n = 0, asynchronous): hour = 0, minute = 0, second = 0, field = 0, editing = 0, commit = 0. All edge-detect and hold counters are cleared; state is IDLE.
- FSM states: IDLE, EDIT.
  - IDLE → EDIT at an edge with edit_en = 1. At that edge, load hour/minute/second from cur_*, set field = 0 and editing = 1. Buttons are ignored on this entry edge.
  - EDIT → IDLE at an edge with edit_en = 0. At that edge, commit = 1 for exactly one cycle and editing = 0. Working values hold unchanged in IDLE.
  - In IDLE, all buttons are ignored and commit = 0.
- Field select: each rising edge of btn_next in EDIT advances field 0→1→2→0.
- Step rule (EDIT only):
  - Increment: value == MAX → 0, otherwise value + 1.
  - Decrement: value == 0 → MAX, otherwise value − 1.
  - Only the selected field changes.
  - If a loaded cur_* value exceeds its MAX, it is taken as-is. The next increment wraps it to 0; the next decrement gives value − 1.
- Press/repeat for an active key (inc xor dec):
  - Step on the first edge the key is seen high after being low.
  - A hold counter then runs. Further steps occur at HOLD_CYCLES after the first step, then every REPEAT_CYCLES, while the key stays high.
  - Key release, or a change of active key, clears the hold counter.
- Simultaneous events:
  - inc and dec both high: no step; the hold counter is cleared and held.
  - btn_next rising in the same cycle as a step: the step applies to the old field; field advances at the same edge.
  - edit_en falling in the same cycle as a step or btn_next: exit wins, no step, commit asserted.
- Reset mid-edit: outputs go immediately to their reset values; no commit pulse.

## Timing
- Edge detection uses each button's sample from the previous clock edge. A key high at edge k and low at edge k−1 steps the value, visible after edge k (one-cycle latency from input to output).
- With the key held continuously from edge k, steps occur at edges k, k+HOLD_CYCLES, k+HOLD_CYCLES+REPEAT_CYCLES, k+HOLD_CYCLES+2·REPEAT_CYCLES, ...
- commit is high for the single cycle after the edge where edit_en is seen low. It never asserts twice without an intervening EDIT entry.
- Inputs are synchronous to clk; synchronisers and debounce live upstream.

## Test plan
Bench parameters: HOLD_CYCLES = 4, REPEAT_CYCLES = 2, default MAX values.
- Entry load: cur = 12:34:56, raise edit_en → next cycle hour = 12, minute = 34, second = 56, field = 0, editing = 1.
- Wrap up and down: field = 0 with hour = 23, pulse btn_inc one cycle → hour = 0. Then pulse btn_dec → hour = 23. Minute and second are unchanged throughout.
- Auto-repeat: field = 1, minute = 58, hold btn_inc for 10 cycles starting at edge k → steps at edges k, k+4, k+6, k+8, giving minute 59, 0, 1, 2.
- Field cycling and conflict: pulse btn_next three times → field goes 1, 2, 0. Hold btn_inc and btn_dec together for 8 cycles → no value change.
- Commit: after editing to 07:05:09, drop edit_en → commit = 1 for exactly one cycle with outputs 07:05:09, then editing = 0. Buttons pressed afterwards in IDLE cause no change.
- Reset mid-edit: assert rst_n = 0 during an auto-repeat → all outputs go to 0 asynchronously with no commit. After release, state is IDLE.
